// File: rtl/interp_pkg.sv
// Shared constants, FSM encoding and helper functions for the fractional-sample
// interpolation sequencer.
package interp_pkg;

  localparam int FRAC_W   = 2;
  localparam int NUM_FILT = 15;
  localparam int SEL_W    = 4;
  localparam int DIM_MIN  = 4;
  localparam int DIM_MAX  = 64;
  localparam int CNT_W    = 6;

  // The mux default input sits just past the last filter index
  localparam logic [SEL_W-1:0] SEL_BYPASS = SEL_W'(NUM_FILT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] phase_select(input logic [FRAC_W-1:0] fx,
                                                    input logic [FRAC_W-1:0] fy);
    logic [SEL_W-1:0] idx;
    idx = {fy, fx};
    return (idx == '0) ? SEL_BYPASS : idx - SEL_W'(1);
  endfunction

  function automatic logic dim_legal(input int unsigned d);
    return (d >= DIM_MIN) && (d <= DIM_MAX) && ((d % 4) == 0);
  endfunction

endpackage

// File: rtl/interp_valid_pipe.sv
// Enable-gated shift register carrying a valid bit and a tag; models the
// filter-bank latency so the tag emerges alongside the filtered sample.
module interp_valid_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else if (en) begin
      valid_q[0] <= in_valid;
      tag_q[0]   <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/interp_sel_ctrl.sv
// Block sequencer for the interpolation datapath: walks a WxH block, drives the
// reference-buffer advance and tags filtered samples with column/row.
module interp_sel_ctrl
  import interp_pkg::*;
#(
  parameter int FILT_LAT = 2,
  parameter int DIM_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       frac_x,
  input  logic [1:0]       frac_y,
  input  logic [DIM_W-1:0] blk_w,
  input  logic [DIM_W-1:0] blk_h,
  input  logic             out_ready,
  output logic             rd_en,
  output logic [3:0]       select,
  output logic             bypass,
  output logic             out_valid,
  output logic [5:0]       col,
  output logic [5:0]       row,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] col_i, row_i;
  logic [CNT_W-1:0] w_last, h_last;
  logic             job_ok, accept, at_last, last_xfer;
  logic [2*CNT_W-1:0] out_tag;

  assign job_ok    = dim_legal(32'(blk_w)) && dim_legal(32'(blk_h));
  assign accept    = (state == ST_IDLE) && start && job_ok;
  assign at_last   = (col_i == w_last) && (row_i == h_last);
  assign rd_en     = (state == ST_RUN) && out_ready;
  assign busy      = (state != ST_IDLE);
  // The final tag is unique within a job, so seeing it transfer means the pipe is empty
  assign last_xfer = (state == ST_DRAIN) && out_valid && out_ready &&
                     (col == w_last) && (row == h_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)           state_nxt = ST_RUN;
      ST_RUN:   if (rd_en && at_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_xfer)        state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_last <= '0;
      h_last <= '0;
      select <= '0;
      bypass <= 1'b0;
    end else if (accept) begin
      w_last <= CNT_W'(blk_w - DIM_W'(1));
      h_last <= CNT_W'(blk_h - DIM_W'(1));
      select <= phase_select(frac_x, frac_y);
      bypass <= (frac_x == 2'd0) && (frac_y == 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_i <= '0;
      row_i <= '0;
    end else if (accept) begin
      col_i <= '0;
      row_i <= '0;
    end else if (rd_en) begin
      if (col_i == w_last) begin
        col_i <= '0;
        row_i <= row_i + CNT_W'(1);
      end else begin
        col_i <= col_i + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      err  <= (state == ST_IDLE) && start && !job_ok;
      done <= last_xfer;
    end
  end

  interp_valid_pipe #(
    .DEPTH (FILT_LAT),
    .TAG_W (2*CNT_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (out_ready),
    .in_valid  (rd_en),
    .in_tag    ({row_i, col_i}),
    .out_valid (out_valid),
    .out_tag   (out_tag)
  );

  assign row = out_tag[2*CNT_W-1:CNT_W];
  assign col = out_tag[CNT_W-1:0];

endmodule
